// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for the word-addressed data memory; sub-word stores are read-modify-write.
// Optional misaligned-access exceptions are enabled by defining LSU_MISALIGN_EXC_EN.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_exc,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_read_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state, state_nxt;
  logic              lat_we, lat_uns;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       load_ext, merged;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic              accept, misalign;

  assign accept = req_valid & (state == S_IDLE);

`ifdef LSU_MISALIGN_EXC_EN
  assign misalign = ((req_size == 2'b01) & req_addr[0]) | (req_size[1] & (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (misalign)                  state_nxt = S_RESP;
          else if (req_we && req_size[1]) state_nxt = S_WR;
          else                           state_nxt = S_RD;
        end
      end
      S_RD:    state_nxt = lat_we ? S_WR : S_RESP;
      S_WR:    state_nxt = S_RESP;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores
  always_comb begin
    lane_b   = mem_read_data[{lat_addr[1:0], 3'b000} +: 8];
    lane_h   = lat_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    load_ext = mem_read_data;
    merged   = mem_read_data;
    case (lat_size)
      2'b00: begin
        load_ext = lat_uns ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
        merged[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
      end
      2'b01: begin
        load_ext = lat_uns ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
        merged[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
      end
      default: merged = lat_wdata;
    endcase
  end

  // Request latch and response data
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_we     <= 1'b0;
      lat_uns    <= 1'b0;
      lat_size   <= 2'b00;
      lat_addr   <= '0;
      lat_wdata  <= 32'h0;
      resp_rdata <= 32'h0;
      resp_exc   <= 1'b0;
    end else if (accept) begin
      lat_we     <= req_we;
      lat_uns    <= req_unsigned;
      lat_size   <= req_size;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
      resp_rdata <= 32'h0;
      resp_exc   <= misalign;
    end else if (state == S_RD) begin
      if (lat_we) lat_wdata  <= merged;
      else        resp_rdata <= load_ext;
    end
  end

  // Memory strobes are qualified by reset so a reset during WR drops the write
  assign req_ready      = (state == S_IDLE);
  assign resp_valid     = reset & (state == S_RESP);
  assign mem_read       = reset & (state == S_RD);
  assign mem_write      = reset & (state == S_WR);
  assign mem_address    = (reset && (state == S_RD || state == S_WR)) ?
                          {lat_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_write_data = (reset && state == S_WR) ? lat_wdata : 32'h0;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage initiator for the word-addressed data memory of the MIPS core. Accepts one load/store request at a time from the pipeline, drives the memory's `address`/`write_data`/`mem_write`/`mem_read` interface, and returns load data extended to 32 bits. Byte and halfword stores are performed as read-modify-write, because the data memory only writes whole words.

## Interface
Parameters:
- `ADDR_W`, 32: width of request and memory addresses.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on a cycle with `req_valid & req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data; byte in [7:0], half in [15:0].
- `resp_valid`  out  1  one-cycle completion pulse, for loads and stores.
- `resp_rdata`  out  32  extended load data; 0 for stores.
- `resp_exc`  out  1  misaligned-access flag; constant 0 unless the macro is defined.
- `mem_address`  out  ADDR_W  word-aligned address ([1:0] = 00).
- `mem_write_data`  out  32  full word to write.
- `mem_write`  out  1  write strobe; memory writes on the next rising edge.
- `mem_read`  out  1  read qualifier.
- `mem_read_data`  in  32  combinational read data for `mem_address`.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE:
  - `req_ready`=1.
  - On accept, latch we/size/unsigned/addr/wdata.
  - Next state: load or sub-word store → RD; word store → WR; misaligned with macro → RESP with exc.
- RD:
  - `mem_read`=1, `mem_address`={addr[ADDR_W-1:2],2'b00}.
  - Load: extract lane, extend, latch into `resp_rdata`, go to RESP.
  - Sub-word store: merge store data into `mem_read_data`, latch the merged word, go to WR.
- WR: `mem_write`=1 for exactly one cycle, `mem_write_data` = latched word (`req_wdata` for `sw`); next state RESP.
- RESP: `resp_valid`=1 for one cycle; next state IDLE.
- Lane selection, little-endian:
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
  - Word uses the full 32 bits.
- Merge: only the selected lane is replaced; the other bytes keep the values read in RD.
- `mem_address` is 0 outside RD/WR. `mem_write_data` is 0 outside WR.
- `mem_read` and `mem_write` are gated with `reset`: neither is asserted in any cycle where `reset`=0.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready`=1 after reset.
  - `resp_valid`=0, `resp_rdata`=0, `resp_exc`=0.
  - `mem_*` outputs = 0.
- Latency, with the accept at cycle T:
  - Load: RD at T+1, `resp_valid` at T+2.
  - Word store: WR at T+1, `resp_valid` at T+2.
  - Byte/half store: RD at T+1, WR at T+2, `resp_valid` at T+3.
  - Misaligned with macro: `resp_valid`+`resp_exc` at T+1; no memory access.
- `resp_rdata` and `resp_exc` hold their values until the next accept.
- Back-to-back: a new request may be accepted on the cycle after RESP (IDLE). `req_valid` held during a busy period is simply not accepted.
- Reset mid-operation (any state): the next state is IDLE, latched data is cleared, and the pending write is dropped. Memory is unchanged if reset is low during WR.

## Configuration
- `LSU_MISALIGN_EXC_EN` defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠00, is misaligned.
  - Misaligned accesses are not performed; the unit returns `resp_exc`=1 and `resp_rdata`=0.
- Undefined:
  - `resp_exc` is tied to 0.
  - Misaligned low bits are ignored: half uses addr[1] only, word ignores addr[1:0].

## Test plan
- Reset held low for 2 cycles with `req_valid`=1 → no accept, all outputs at reset values; `req_ready`=1 on the first cycle after release.
- `sw` 0xDEADBEEF to 0x10 → `mem_write`=1 at T+1 with address 0x10, `resp_valid` at T+2; then `lw` 0x10 → `resp_rdata`=0xDEADBEEF at T+2.
- Word 0x123480FF at 0x10:
  - `lb` 0x11 → 0xFFFFFF80.
  - `lbu` 0x11 → 0x00000080.
  - `lh` 0x12 → 0x00001234.
- `sb` 0xAB to 0x12 over word 0x123480FF → RD at T+1, write of 0x12AB80FF at T+2, `resp_valid` at T+3.
- `lh` 0x13:
  - With macro: `resp_exc`=1 at T+1, `mem_read` never asserted.
  - Without macro: treated as 0x12, returns the sign-extended upper half.
- `sh` 0xBEEF to 0x10 with reset pulled low during WR → `mem_write`=0 that cycle, memory word unchanged, unit in IDLE afterward.
